blackjack_round_ctrl: RTL and testbench
=======================================

# blackjack_round_ctrl

Round sequencer for the blackjack datapath. Drives the sum/compare unit's `clear_sums`, `deal_player`, `deal_dealer`, `stand_active` and `compare` controls. Runs the card-source request/ready handshake and walks a round through clear, initial four-card deal, player turn, dealer auto-draw and result. Keeps saturating win/loss/tie tallies across rounds.

## Interface
- `CARD_TIMEOUT`, 1024: max cycles in DEAL_WAIT without `card_ready` before ERROR (≥2)
- `CNT_W`, 8: width of each tally counter
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `start_btn`, `hit_btn`, `stand_btn` in 1 each: synchronous one-cycle pulses, already debounced
- `card_ready` in 1: card source has `card_value` valid; held high ≥1 cycle, then returns low
- `player_sum` in 6: player total from the sum unit
- `player_bust`, `dealer_auto_hit` in 1 each: flags from the sum unit
- `player_win`, `dealer_win`, `tie` in 1 each: compare results, valid while `compare`=1
- `card_req` out 1: request next card (level)
- `clear_sums`, `deal_player`, `deal_dealer` out 1 each: one-cycle pulses
- `stand_active`, `compare` out 1 each: levels
- `state_code` out 4: current state encoding
- `error` out 1: high in ERROR
- `player_wins`, `dealer_wins`, `ties` out CNT_W each: saturating tallies

## Operation
- State encodings: IDLE=0, CLEAR=1, DEAL_REQ=2, DEAL_WAIT=3, DEAL_ACK=4, DEAL_SETTLE=5, PLAYER_TURN=6, DEALER_TURN=7, RESULT=8, ERROR=9.
- IDLE, RESULT, ERROR: `start_btn` → CLEAR. `start_btn` is ignored in all other states.
- CLEAR (1 cycle): `clear_sums`=1, `stand_active`←0, `deal_step`←0, `target`←player → DEAL_REQ.
- DEAL_REQ (1 cycle):
  - `card_req`=1.
  - `deal_player`=1 if `target`=player, else `deal_dealer`=1.
  - Timeout counter ←0 → DEAL_WAIT.
- DEAL_WAIT: `card_req`=1.
  - `card_ready`=1 → DEAL_ACK.
  - Otherwise counter+1; counter reaching CARD_TIMEOUT−1 → ERROR.
- DEAL_ACK: `card_req`=0; stay until `card_ready`=0 → DEAL_SETTLE. No timeout.
- DEAL_SETTLE (1 cycle, lets sums update), then dispatch:
  - Initial deal with `deal_step`<3: `deal_step`+1, `target` alternates (player, dealer, player, dealer) → DEAL_REQ.
  - `deal_step`=3 (4th card done): `player_sum`=21 → DEALER_TURN with `stand_active`←1; else → PLAYER_TURN.
  - Player hit: `player_bust` → RESULT; `player_sum`=21 → DEALER_TURN (auto-stand); else → PLAYER_TURN.
  - Dealer draw → DEALER_TURN.
- PLAYER_TURN:
  - `stand_btn` → `stand_active`←1 → DEALER_TURN.
  - Else `hit_btn` → `target`←player → DEAL_REQ.
  - Simultaneous hit+stand: stand wins, hit dropped.
- DEALER_TURN: `dealer_auto_hit`=1 → `target`←dealer → DEAL_REQ; else → RESULT.
- RESULT: `compare`=1 for the whole state.
  - First cycle only: increment `player_wins`, `dealer_wins` or `ties` per the asserted flag.
  - Saturate at 2^CNT_W−1. No flag asserted → no increment.
- ERROR: `card_req`=0, `error`=1; wait for `start_btn`.
- `stand_active` stays held from stand until the next CLEAR, including across dealer DEAL_* states and RESULT.
- Tallies are cleared only by `rst`.

## Timing
- Reset (async, immediate):
  - All outputs 0, `state_code`=0, tallies 0.
  - `deal_step`=0, timeout counter 0.
  - Mid-handshake reset drops `card_req` the same instant.
- `start_btn` in cycle N: `clear_sums`=1 in N+1; DEAL_REQ in N+2 (`card_req` and `deal_player` both 1).
- `card_req` rises together with the deal pulse. It falls the cycle after `card_ready` is first sampled high.
- Card cost: 1 (REQ) + k (WAIT, k≥1) + m (ACK) + 1 (SETTLE) cycles.
- Timeout: ERROR is entered after exactly CARD_TIMEOUT cycles in DEAL_WAIT with `card_ready` low.
- Button pulses arriving outside PLAYER_TURN (other than `start_btn` as above) are ignored, not queued.
- `card_ready` high outside DEAL_WAIT/DEAL_ACK is ignored.

## Test plan
- Full round, instant-ready source, cards 10,7,9,10, then stand:
  - Four alternating deal pulses, then PLAYER_TURN with `player_sum`=19.
  - Stand → DEALER_TURN; `dealer_auto_hit`=0 → RESULT; `compare`=1.
  - `player_win`=1 → `player_wins`=1.
- Hit to bust: deal 10,5,6,10, hit card 10 (`player_sum`=26, bust) → RESULT straight from DEAL_SETTLE. No `deal_dealer` after the hit; `stand_active`=0.
- Same-cycle `hit_btn`+`stand_btn` in PLAYER_TURN → DEALER_TURN, no `deal_player` pulse, `stand_active`=1.
- CARD_TIMEOUT=8, `card_ready` held low → ERROR after 8 WAIT cycles, `card_req`=0, `error`=1. Then `start_btn` → CLEAR with `clear_sums` pulse.
- `rst` asserted in DEAL_WAIT with `card_req`=1 → all outputs 0 asynchronously; after release, `state_code`=0.
- CNT_W=2, four forced player wins → `player_wins` reaches 3 and stays 3; other tallies unchanged.

Source files
------------

// File: rtl/blackjack_round_ctrl_if.sv
// Control/status bundle between the round sequencer and its card source / sum unit.
// Controller drives from the master side; the datapath and card source sit on the slave side.
interface blackjack_round_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start_btn;
    logic             hit_btn;
    logic             stand_btn;
    logic             card_ready;
    logic [5:0]       player_sum;
    logic             player_bust;
    logic             dealer_auto_hit;
    logic             player_win;
    logic             dealer_win;
    logic             tie;
    logic             card_req;
    logic             clear_sums;
    logic             deal_player;
    logic             deal_dealer;
    logic             stand_active;
    logic             compare;
    logic [3:0]       state_code;
    logic             error;
    logic [CNT_W-1:0] player_wins;
    logic [CNT_W-1:0] dealer_wins;
    logic [CNT_W-1:0] ties;

    modport master (
        input  start_btn, hit_btn, stand_btn, card_ready, player_sum, player_bust,
               dealer_auto_hit, player_win, dealer_win, tie,
        output card_req, clear_sums, deal_player, deal_dealer, stand_active, compare,
               state_code, error, player_wins, dealer_wins, ties
    );

    modport slave (
        output start_btn, hit_btn, stand_btn, card_ready, player_sum, player_bust,
               dealer_auto_hit, player_win, dealer_win, tie,
        input  card_req, clear_sums, deal_player, deal_dealer, stand_active, compare,
               state_code, error, player_wins, dealer_wins, ties
    );
endinterface

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: clear, 4-card deal, player turn, dealer auto-draw, result, tallies.
// All outputs registered; each card costs REQ + WAIT(k) + ACK(m) + SETTLE, WAIT times out to ERROR.
module blackjack_round_ctrl #(
    parameter int CARD_TIMEOUT = 1024,
    parameter int CNT_W        = 8
) (
    input logic                    clk,
    input logic                    rst,
    blackjack_round_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        CLEAR       = 4'd1,
        DEAL_REQ    = 4'd2,
        DEAL_WAIT   = 4'd3,
        DEAL_ACK    = 4'd4,
        DEAL_SETTLE = 4'd5,
        PLAYER_TURN = 4'd6,
        DEALER_TURN = 4'd7,
        RESULT      = 4'd8,
        ERROR       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        KIND_INIT = 2'd0,
        KIND_HIT  = 2'd1,
        KIND_DRAW = 2'd2
    } kind_t;

    localparam int               TO_W    = $clog2(CARD_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(CARD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    kind_t            kind;
    logic [1:0]       deal_step;
    logic             target_dealer;
    logic [TO_W-1:0]  to_cnt;
    logic             result_first;
    logic             card_req_q, clear_q, deal_player_q, deal_dealer_q;
    logic             stand_q, compare_q, error_q;
    logic [CNT_W-1:0] player_wins_q, dealer_wins_q, ties_q;

    // Outputs are set on the transition into the state that owns them, so they are flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            kind          <= KIND_INIT;
            deal_step     <= 2'd0;
            target_dealer <= 1'b0;
            to_cnt        <= '0;
            result_first  <= 1'b0;
            card_req_q    <= 1'b0;
            clear_q       <= 1'b0;
            deal_player_q <= 1'b0;
            deal_dealer_q <= 1'b0;
            stand_q       <= 1'b0;
            compare_q     <= 1'b0;
            error_q       <= 1'b0;
            player_wins_q <= '0;
            dealer_wins_q <= '0;
            ties_q        <= '0;
        end else begin
            card_req_q    <= 1'b0;
            clear_q       <= 1'b0;
            deal_player_q <= 1'b0;
            deal_dealer_q <= 1'b0;
            compare_q     <= 1'b0;
            error_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_btn) begin
                        state   <= CLEAR;
                        clear_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    stand_q       <= 1'b0;
                    deal_step     <= 2'd0;
                    target_dealer <= 1'b0;
                    kind          <= KIND_INIT;
                    state         <= DEAL_REQ;
                    card_req_q    <= 1'b1;
                    deal_player_q <= 1'b1;
                end
                DEAL_REQ: begin
                    to_cnt     <= '0;
                    state      <= DEAL_WAIT;
                    card_req_q <= 1'b1;
                end
                DEAL_WAIT: begin
                    if (bus.card_ready) begin
                        state <= DEAL_ACK;
                    end else if (to_cnt == TO_LAST) begin
                        state   <= ERROR;
                        error_q <= 1'b1;
                    end else begin
                        to_cnt     <= to_cnt + 1'b1;
                        card_req_q <= 1'b1;
                    end
                end
                DEAL_ACK: begin
                    if (!bus.card_ready) state <= DEAL_SETTLE;
                end
                DEAL_SETTLE: begin
                    case (kind)
                        KIND_INIT: begin
                            if (deal_step != 2'd3) begin
                                deal_step     <= deal_step + 2'd1;
                                target_dealer <= !target_dealer;
                                state         <= DEAL_REQ;
                                card_req_q    <= 1'b1;
                                deal_player_q <= target_dealer;
                                deal_dealer_q <= !target_dealer;
                            end else if (bus.player_sum == 6'd21) begin
                                stand_q <= 1'b1;
                                state   <= DEALER_TURN;
                            end else begin
                                state <= PLAYER_TURN;
                            end
                        end
                        KIND_HIT: begin
                            if (bus.player_bust) begin
                                state        <= RESULT;
                                compare_q    <= 1'b1;
                                result_first <= 1'b1;
                            end else if (bus.player_sum == 6'd21) begin
                                stand_q <= 1'b1;
                                state   <= DEALER_TURN;
                            end else begin
                                state <= PLAYER_TURN;
                            end
                        end
                        default: state <= DEALER_TURN;
                    endcase
                end
                PLAYER_TURN: begin
                    // Stand has priority; a simultaneous hit is dropped.
                    if (bus.stand_btn) begin
                        stand_q <= 1'b1;
                        state   <= DEALER_TURN;
                    end else if (bus.hit_btn) begin
                        target_dealer <= 1'b0;
                        kind          <= KIND_HIT;
                        state         <= DEAL_REQ;
                        card_req_q    <= 1'b1;
                        deal_player_q <= 1'b1;
                    end
                end
                DEALER_TURN: begin
                    if (bus.dealer_auto_hit) begin
                        target_dealer <= 1'b1;
                        kind          <= KIND_DRAW;
                        state         <= DEAL_REQ;
                        card_req_q    <= 1'b1;
                        deal_dealer_q <= 1'b1;
                    end else begin
                        state        <= RESULT;
                        compare_q    <= 1'b1;
                        result_first <= 1'b1;
                    end
                end
                RESULT: begin
                    if (result_first) begin
                        result_first <= 1'b0;
                        if (bus.player_win) begin
                            if (player_wins_q != CNT_MAX) player_wins_q <= player_wins_q + 1'b1;
                        end else if (bus.dealer_win) begin
                            if (dealer_wins_q != CNT_MAX) dealer_wins_q <= dealer_wins_q + 1'b1;
                        end else if (bus.tie) begin
                            if (ties_q != CNT_MAX) ties_q <= ties_q + 1'b1;
                        end
                    end
                    if (bus.start_btn) begin
                        state   <= CLEAR;
                        clear_q <= 1'b1;
                    end else begin
                        compare_q <= 1'b1;
                    end
                end
                ERROR: begin
                    if (bus.start_btn) begin
                        state   <= CLEAR;
                        clear_q <= 1'b1;
                    end else begin
                        error_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.card_req     = card_req_q;
    assign bus.clear_sums   = clear_q;
    assign bus.deal_player  = deal_player_q;
    assign bus.deal_dealer  = deal_dealer_q;
    assign bus.stand_active = stand_q;
    assign bus.compare      = compare_q;
    assign bus.error        = error_q;
    assign bus.state_code   = state;
    assign bus.player_wins  = player_wins_q;
    assign bus.dealer_wins  = dealer_wins_q;
    assign bus.ties         = ties_q;
endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Randomized rounds against a card-level blackjack model; a monitor pops expected events.
module tb_blackjack_round_ctrl;
    localparam int CARD_TIMEOUT = 8;
    localparam int CNT_W        = 2;
    localparam int TALLY_MAX    = (1 << CNT_W) - 1;
    localparam int EV_CLEAR = 0, EV_DP = 1, EV_DD = 2, EV_RES = 3, EV_ERR = 4;

    typedef struct {
        int kind;
        int pw;
        int dw;
        int tw;
        int stand;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blackjack_round_ctrl_if #(.CNT_W(CNT_W)) bus ();
    blackjack_round_ctrl #(.CARD_TIMEOUT(CARD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int  n_chk = 0;
    int  n_fail = 0;
    int  psum = 0;
    int  dsum = 0;
    bit  starve = 1'b0;
    bit  fast = 1'b0;
    int  deck[$];
    int  src_deck[$];
    ev_t exp_q[$];
    int  mpw = 0, mdw = 0, mtw = 0;

    // Sum/compare unit stand-in: plain card totals, no soft aces.
    assign bus.player_sum      = psum[5:0];
    assign bus.player_bust     = psum > 21;
    assign bus.dealer_auto_hit = dsum < 17;
    assign bus.player_win      = (psum <= 21) && (dsum > 21 || psum > dsum);
    assign bus.dealer_win      = (psum > 21) || (dsum <= 21 && dsum > psum);
    assign bus.tie             = (psum <= 21) && (dsum <= 21) && (psum == dsum);

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input int stand);
        ev_t e;
        e.kind = k; e.pw = mpw; e.dw = mdw; e.tw = mtw; e.stand = stand;
        exp_q.push_back(e);
    endtask

    task automatic fill_deck();
        while (deck.size() < 24) deck.push_back(int'($urandom_range(2, 11)));
    endtask

    // Whole-round expectation from the game rules, card by card.
    task automatic model_round(input int thr);
        int p, d, i;
        bit bust;
        p = 0; d = 0; i = 0; bust = 1'b0;
        push(EV_CLEAR, 0);
        for (int c = 0; c < 4; c++) begin
            if (c % 2 == 0) begin p += deck[i]; push(EV_DP, 0); end
            else begin d += deck[i]; push(EV_DD, 0); end
            i++;
        end
        while (p != 21 && p < thr) begin
            p += deck[i]; i++;
            push(EV_DP, 0);
            if (p > 21) bust = 1'b1;
            if (p >= 21) break;
        end
        if (!bust) begin
            while (d < 17) begin d += deck[i]; i++; push(EV_DD, 0); end
        end
        if (bust || (d <= 21 && d > p)) mdw = (mdw < TALLY_MAX) ? mdw + 1 : mdw;
        else if (d > 21 || p > d)       mpw = (mpw < TALLY_MAX) ? mpw + 1 : mpw;
        else                            mtw = (mtw < TALLY_MAX) ? mtw + 1 : mtw;
        push(EV_RES, bust ? 0 : 1);
    endtask

    task automatic run_round(input int thr, input bit force_both);
        int guard, st;
        bit done;
        src_deck = deck;
        model_round(thr);
        @(negedge clk);
        bus.start_btn = 1'b1;
        done = 1'b0; guard = 0;
        while (!done && guard < 3000) begin
            @(negedge clk);
            guard++;
            bus.start_btn = 1'b0; bus.hit_btn = 1'b0; bus.stand_btn = 1'b0;
            st = int'(bus.state_code);
            if (st == 6) begin
                if (psum < thr) bus.hit_btn = 1'b1;
                else begin
                    bus.stand_btn = 1'b1;
                    if (force_both || $urandom_range(0, 2) == 0) bus.hit_btn = 1'b1;
                end
            end else if (st == 8) begin
                done = 1'b1;
            end else if (st != 0 && st != 9 && $urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 2))
                    0: bus.hit_btn = 1'b1;
                    1: bus.stand_btn = 1'b1;
                    default: bus.start_btn = 1'b1;
                endcase
            end
        end
        chk("round_reaches_result", int'(done), 1);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Card source: request seen -> ready after 1..4 cycles, held 1..3 cycles.
    initial begin
        bit to_dealer;
        int card;
        bus.card_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.clear_sums) begin
                psum = 0; dsum = 0;
            end else if (bus.card_req && !bus.card_ready && !starve && !rst) begin
                to_dealer = bus.deal_dealer;
                card = (src_deck.size() > 0) ? src_deck.pop_front() : 2;
                repeat (fast ? 1 : $urandom_range(1, 4)) @(negedge clk);
                bus.card_ready = 1'b1;
                if (to_dealer) dsum += card; else psum += card;
                repeat (fast ? 1 : $urandom_range(1, 3)) @(negedge clk);
                bus.card_ready = 1'b0;
            end
        end
    end

    // Monitor: every visible output event must match the head of the expected queue.
    initial begin
        int  kind, nev;
        bit  cmp_prev, err_prev;
        ev_t e;
        cmp_prev = 1'b0; err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmp_prev = 1'b0; err_prev = 1'b0;
            end else begin
                kind = -1; nev = 0;
                if (bus.clear_sums)               begin kind = EV_CLEAR; nev++; end
                if (bus.deal_player)              begin kind = EV_DP;    nev++; end
                if (bus.deal_dealer)              begin kind = EV_DD;    nev++; end
                if (bus.compare && !cmp_prev)     begin kind = EV_RES;   nev++; end
                if (bus.error && !err_prev)       begin kind = EV_ERR;   nev++; end
                if (nev > 1) chk("one_event_per_cycle", nev, 1);
                if (kind >= 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_event", kind, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_kind", kind, e.kind);
                        if (kind == EV_DP || kind == EV_DD) begin
                            chk("card_req_with_deal", int'(bus.card_req), 1);
                            chk("deal_state", int'(bus.state_code), 2);
                        end else if (kind == EV_ERR) begin
                            chk("card_req_in_error", int'(bus.card_req), 0);
                        end else if (kind == EV_RES) begin
                            chk("stand_active_at_result", int'(bus.stand_active), e.stand);
                            @(negedge clk);
                            chk("compare_held", int'(bus.compare), 1);
                            chk("player_wins", int'(bus.player_wins), e.pw);
                            chk("dealer_wins", int'(bus.dealer_wins), e.dw);
                            chk("ties", int'(bus.ties), e.tw);
                        end
                    end
                end
                cmp_prev = bus.compare;
                err_prev = bus.error;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt, st;
        bus.start_btn = 1'b0; bus.hit_btn = 1'b0; bus.stand_btn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state_code", int'(bus.state_code), 0);
        chk("reset_card_req", int'(bus.card_req), 0);
        chk("reset_clear_sums", int'(bus.clear_sums), 0);
        chk("reset_deal", int'(bus.deal_player) + int'(bus.deal_dealer), 0);
        chk("reset_stand_compare_error", int'(bus.stand_active) + int'(bus.compare) + int'(bus.error), 0);
        chk("reset_tallies", int'(bus.player_wins) + int'(bus.dealer_wins) + int'(bus.ties), 0);
        rst = 1'b0;
        @(negedge clk);

        // 10,7,9,10 then stand: player 19 vs dealer 17.
        fast = 1'b1;
        deck = '{10, 7, 9, 10}; fill_deck();
        run_round(0, 1'b0);
        // 10,5,6,10 then hit 10 -> 26 bust.
        deck = '{10, 5, 6, 10, 10}; fill_deck();
        run_round(17, 1'b0);
        // Hit and stand together: stand wins.
        deck = '{10, 7, 9, 10}; fill_deck();
        run_round(0, 1'b1);
        fast = 1'b0;

        // Starved source: exactly CARD_TIMEOUT WAIT cycles then ERROR.
        starve = 1'b1;
        push(EV_CLEAR, 0); push(EV_DP, 0); push(EV_ERR, 0);
        @(negedge clk);
        bus.start_btn = 1'b1;
        wait_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.start_btn = 1'b0;
            st = int'(bus.state_code);
            if (st == 3) wait_cnt++;
            if (st == 9) break;
        end
        chk("timeout_wait_cycles", wait_cnt, CARD_TIMEOUT);
        chk("error_state_code", int'(bus.state_code), 9);
        chk("error_flag", int'(bus.error), 1);
        chk("error_card_req", int'(bus.card_req), 0);
        starve = 1'b0;
        deck.delete(); fill_deck();
        run_round(int'($urandom_range(12, 18)), 1'b0);

        // Four sure player wins push the 2-bit tally into saturation.
        for (int r = 0; r < 4; r++) begin
            deck = '{10, 7, 10, 10}; fill_deck();
            run_round(0, 1'b0);
        end

        for (int r = 0; r < 30; r++) begin
            deck.delete(); fill_deck();
            run_round(int'($urandom_range(10, 21)), 1'b0);
        end

        // Asynchronous reset while a card request is outstanding.
        starve = 1'b1;
        push(EV_CLEAR, 0); push(EV_DP, 0);
        @(negedge clk);
        bus.start_btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            bus.start_btn = 1'b0;
            if (int'(bus.state_code) == 3) break;
        end
        chk("pre_reset_card_req", int'(bus.card_req), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_card_req", int'(bus.card_req), 0);
        chk("async_reset_state_code", int'(bus.state_code), 0);
        chk("async_reset_tallies", int'(bus.player_wins) + int'(bus.dealer_wins) + int'(bus.ties), 0);
        chk("async_reset_levels", int'(bus.stand_active) + int'(bus.compare) + int'(bus.error), 0);
        exp_q.delete();
        mpw = 0; mdw = 0; mtw = 0;
        @(negedge clk);
        rst = 1'b0;
        starve = 1'b0;
        @(negedge clk);
        chk("post_reset_state_code", int'(bus.state_code), 0);
        deck.delete(); fill_deck();
        run_round(int'($urandom_range(12, 18)), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
